// File: rtl/serial_nibble_rx_pkg.sv
// Shared state encoding and default sizing for the serial nibble receiver.
package serial_nibble_rx_pkg;

    localparam int unsigned DEF_DATA_W       = 4;
    localparam int unsigned DEF_CLKS_PER_BIT = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        WAIT_HI = 3'd5
    } rx_state_t;

endpackage

// File: rtl/serial_bit_timer.sv
// Modulo-CLKS_PER_BIT bit-period counter with clear and terminal/half-point flags.
module serial_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned CNT_W        = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             terminal,
    output logic             half
);

    assign terminal = (cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign half     = (cnt == CNT_W'(CLKS_PER_BIT / 2 - 1));

    always_ff @(posedge Clk) begin
        if (Rst || clr || terminal) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/serial_nibble_rx.sv
// Serial frame receiver: start, DATA_W bits LSB first, stop; strobes Load on a good word.
// Optional even-parity bit between data and stop when SIN_PARITY_EN is defined.
module serial_nibble_rx
    import serial_nibble_rx_pkg::*;
#(
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Sin,
    output logic [DATA_W-1:0] Dout,
    output logic              Load,
    output logic              FrameErr,
    output logic              Busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_W);

    rx_state_t         state;
    logic              sin_q;
    logic [DATA_W-1:0] shreg;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  cnt;
    logic              terminal;
    logic              half;
    logic              timer_clr;

    // Data/parity/stop transitions land on the terminal count, where the timer wraps by itself.
    always_comb begin
        timer_clr = 1'b0;
        if (state == IDLE || state == WAIT_HI || (state == START && half)) begin
            timer_clr = 1'b1;
        end
    end

    serial_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_timer (
        .Clk      (Clk),
        .Rst      (Rst),
        .clr      (timer_clr),
        .cnt      (cnt),
        .terminal (terminal),
        .half     (half)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            sin_q    <= 1'b1;
            shreg    <= '0;
            idx      <= '0;
            Dout     <= '0;
            Load     <= 1'b0;
            FrameErr <= 1'b0;
            Busy     <= 1'b0;
        end else begin
            sin_q    <= Sin;
            Load     <= 1'b0;
            FrameErr <= 1'b0;
            case (state)
                IDLE: begin
                    if (!sin_q) begin
                        state <= START;
                        Busy  <= 1'b1;
                    end
                end
                START: begin
                    if (half) begin
                        if (sin_q) begin
                            state <= IDLE;
                            Busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                            idx   <= '0;
                        end
                    end
                end
                DATA: begin
                    if (terminal) begin
                        shreg <= {sin_q, shreg[DATA_W-1:1]};
                        idx   <= idx + 1'b1;
                        if (idx == IDX_W'(DATA_W - 1)) begin
`ifdef SIN_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef SIN_PARITY_EN
                PARITY: begin
                    if (terminal) begin
                        if (sin_q != ^shreg) begin
                            FrameErr <= 1'b1;
                            if (sin_q) begin
                                state <= IDLE;
                                Busy  <= 1'b0;
                            end else begin
                                state <= WAIT_HI;
                            end
                        end else begin
                            state <= STOP;
                        end
                    end
                end
`endif
                STOP: begin
                    if (terminal) begin
                        if (sin_q) begin
                            Dout  <= shreg;
                            Load  <= 1'b1;
                            state <= IDLE;
                            Busy  <= 1'b0;
                        end else begin
                            FrameErr <= 1'b1;
                            state    <= WAIT_HI;
                        end
                    end
                end
                WAIT_HI: begin
                    // A held-low break must not be mistaken for a new start bit.
                    if (sin_q) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_nibble_rx.sv
// Self-checking bench for serial_nibble_rx with randomized frames and a timing-level model.
module tb_serial_nibble_rx;

    localparam int DW  = 4;
    localparam int CPB = 4;
    localparam int H   = CPB / 2;
`ifdef SIN_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    // Strobe appears this many edges after the edge that first registers the start bit low.
    localparam int LAT     = 1 + H + CPB * (DW + 1 + PB);
    localparam int ERR_PAR = 1 + H + CPB * (DW + 1);

    logic          Clk = 1'b0;
    logic          Rst;
    logic          Sin;
    logic [DW-1:0] Dout;
    logic          Load;
    logic          FrameErr;
    logic          Busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [DW-1:0] last_good = '0;

    int            load_cyc[$];
    logic [DW-1:0] load_dat[$];
    logic          load_busy[$];
    int            fe_cyc[$];

    serial_nibble_rx #(
        .DATA_W       (DW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Sin      (Sin),
        .Dout     (Dout),
        .Load     (Load),
        .FrameErr (FrameErr),
        .Busy     (Busy)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (Load) begin
            load_cyc.push_back(cyc);
            load_dat.push_back(Dout);
            load_busy.push_back(Busy);
        end
        if (FrameErr) fe_cyc.push_back(cyc);
        if (Load && FrameErr) begin
            errors++;
            $display("FAIL strobe_overlap: Load=1 FrameErr=1 at cycle %0d, required not both", cyc);
        end
    end

    task automatic clear_log();
        load_cyc.delete();
        load_dat.delete();
        load_busy.delete();
        fe_cyc.delete();
    endtask

    task automatic drive_bit(input logic b);
        Sin = b;
        repeat (CPB) @(negedge Clk);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic stop_b, input logic par_b,
                              output int k);
        k = cyc + 1;
        drive_bit(1'b0);
        for (int i = 0; i < DW; i++) drive_bit(d[i]);
        if (PB == 1) drive_bit(par_b);
        drive_bit(stop_b);
        Sin = 1'b1;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        Sin = 1'b1;
        repeat (3) @(negedge Clk);
        checks++; if (Dout !== '0) begin errors++; $display("FAIL reset_dout: got %h want 0", Dout); end
        checks++; if (Load !== 1'b0) begin errors++; $display("FAIL reset_load: got %b want 0", Load); end
        checks++; if (FrameErr !== 1'b0) begin errors++; $display("FAIL reset_fe: got %b want 0", FrameErr); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
        Rst = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_good_frames();
        logic [DW-1:0] d;
        int k;
        for (int n = 0; n < 8; n++) begin
            d = (n == 0) ? 4'hA : DW'($urandom_range(0, 15));
            clear_log();
            send_frame(d, 1'b1, ^d, k);
            repeat (2 * CPB) @(negedge Clk);
            checks++;
            if (load_cyc.size() != 1) begin
                errors++; $display("FAIL good_load_count: frame %h got %0d strobes want 1", d, load_cyc.size());
            end else begin
                checks++;
                if (load_cyc[0] != k + LAT) begin
                    errors++; $display("FAIL good_latency: frame %h got cycle %0d want %0d", d, load_cyc[0], k + LAT);
                end
                checks++;
                if (load_dat[0] !== d) begin
                    errors++; $display("FAIL good_dout: got %h want %h", load_dat[0], d);
                end
                checks++;
                if (load_busy[0] !== 1'b0) begin
                    errors++; $display("FAIL good_busy_fall: got Busy=%b at strobe want 0", load_busy[0]);
                end
                last_good = d;
            end
            checks++;
            if (fe_cyc.size() != 0) begin
                errors++; $display("FAIL good_no_fe: frame %h got %0d FrameErr want 0", d, fe_cyc.size());
            end
        end
    endtask

    task automatic test_glitch();
        clear_log();
        Sin = 1'b0;
        @(negedge Clk);
        Sin = 1'b1;
        @(negedge Clk);
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b want 1", Busy); end
        repeat (2) @(negedge Clk);
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b want 0", Busy); end
        repeat (3 * CPB) @(negedge Clk);
        checks++;
        if (load_cyc.size() + fe_cyc.size() != 0) begin
            errors++; $display("FAIL glitch_no_strobe: got %0d strobes want 0", load_cyc.size() + fe_cyc.size());
        end
    endtask

    task automatic test_frame_err();
        logic [DW-1:0] d;
        int k;
        d = 4'h5;
        clear_log();
        send_frame(d, 1'b0, ^d, k);
        Sin = 1'b0;
        repeat (10) @(negedge Clk);
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL ferr_wait_hi: Busy got %b want 1", Busy); end
        checks++;
        if (fe_cyc.size() != 1) begin
            errors++; $display("FAIL ferr_count: got %0d want 1", fe_cyc.size());
        end else begin
            checks++;
            if (fe_cyc[0] != k + LAT) begin
                errors++; $display("FAIL ferr_cycle: got %0d want %0d", fe_cyc[0], k + LAT);
            end
        end
        checks++; if (load_cyc.size() != 0) begin errors++; $display("FAIL ferr_no_load: got %0d want 0", load_cyc.size()); end
        checks++; if (Dout !== last_good) begin errors++; $display("FAIL ferr_dout_kept: got %h want %h", Dout, last_good); end
        Sin = 1'b1;
        repeat (3) @(negedge Clk);
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL ferr_recover: Busy got %b want 0", Busy); end
        repeat (3 * CPB) @(negedge Clk);
        checks++;
        if (load_cyc.size() != 0 || fe_cyc.size() != 1) begin
            errors++; $display("FAIL ferr_no_false_frame: got loads=%0d fe=%0d want 0/1", load_cyc.size(), fe_cyc.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] fr[3];
        int            ks[3];
        int            n;
        for (int b = 0; b < 2; b++) begin
            if (b == 0) begin
                n = 2; fr[0] = 4'h3; fr[1] = 4'hC;
            end else begin
                n = 3;
                for (int i = 0; i < 3; i++) fr[i] = DW'($urandom_range(0, 15));
            end
            clear_log();
            for (int i = 0; i < n; i++) send_frame(fr[i], 1'b1, ^fr[i], ks[i]);
            repeat (2 * CPB) @(negedge Clk);
            checks++;
            if (load_cyc.size() != n) begin
                errors++; $display("FAIL b2b_count: got %0d want %0d", load_cyc.size(), n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    checks++;
                    if (load_cyc[i] != ks[i] + LAT || load_dat[i] !== fr[i]) begin
                        errors++;
                        $display("FAIL b2b_frame%0d: got cycle %0d data %h want cycle %0d data %h",
                                 i, load_cyc[i], load_dat[i], ks[i] + LAT, fr[i]);
                    end
                end
                last_good = fr[n-1];
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d;
        int k;
        clear_log();
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        Sin = 1'b1;
        repeat (H) @(negedge Clk);
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        repeat (3 * CPB) @(negedge Clk);
        last_good = '0;
        checks++;
        if (load_cyc.size() + fe_cyc.size() != 0) begin
            errors++; $display("FAIL rstmid_no_strobe: got %0d want 0", load_cyc.size() + fe_cyc.size());
        end
        checks++; if (Dout !== last_good) begin errors++; $display("FAIL rstmid_dout: got %h want %h", Dout, last_good); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", Busy); end

        d = 4'h6;
        clear_log();
        send_frame(d, 1'b1, ^d, k);
        repeat (2 * CPB) @(negedge Clk);
        checks++;
        if (load_cyc.size() != 1 || Dout !== d) begin
            errors++; $display("FAIL rstmid_next_frame: got loads=%0d Dout=%h want 1/%h", load_cyc.size(), Dout, d);
        end else begin
            last_good = d;
        end
`ifdef SIN_PARITY_EN
        clear_log();
        send_frame(d, 1'b1, ~(^d), k);
        repeat (2 * CPB) @(negedge Clk);
        checks++;
        if (fe_cyc.size() != 1 || load_cyc.size() != 0) begin
            errors++; $display("FAIL parity_err: got fe=%0d loads=%0d want 1/0", fe_cyc.size(), load_cyc.size());
        end else begin
            checks++;
            if (fe_cyc[0] != k + ERR_PAR) begin
                errors++; $display("FAIL parity_err_cycle: got %0d want %0d", fe_cyc[0], k + ERR_PAR);
            end
        end
        checks++; if (Dout !== last_good) begin errors++; $display("FAIL parity_dout: got %h want %h", Dout, last_good); end
`endif
    endtask

    initial begin
        Rst = 1'b1;
        Sin = 1'b1;
        @(negedge Clk);
        test_reset();
        test_good_frames();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
